// File: rtl/com_to_fifo_if.sv
// FIFO-side write port of the UART receive stage: byte, strobe and FIFO status.
interface com_to_fifo_if;
  logic [7:0] fifo_data;
  logic       fifo_we;
  logic       is_finish;
  logic       fifo_busy;
  logic       fifo_full;

  modport master (
    output fifo_data, fifo_we, is_finish,
    input  fifo_busy, fifo_full
  );

  modport slave (
    input  fifo_data, fifo_we, is_finish,
    output fifo_busy, fifo_full
  );
endinterface

// File: rtl/com_to_fifo.sv
// UART receiver (8N1, or 8 + parity + stop when COM_TO_FIFO_PARITY_EN is defined) writing each byte into a FIFO.
// One-byte holding register decouples reception from FIFO backpressure; a write issues the cycle after a byte is held.
module com_to_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                rx,
  com_to_fifo_if.master       fifo,
  output logic                busy,
  output logic                frame_err,
  output logic                overrun_err,
  output logic                parity_err
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("com_to_fifo: CLKS_PER_BIT must be even and >= 4, PARITY_ODD must be 0 or 1");
  end

`ifdef COM_TO_FIFO_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             rx_m, rx_s;
  logic             byte_vld;
  logic             frame_err_set;
  logic             parity_err_set;
  logic             bit_end;
  logic [7:0]       data_q;
  logic             pending_q;
  logic             wr;

`ifdef COM_TO_FIFO_PARITY_EN
  logic par_q, par_d;
  logic par_bad;
  assign par_bad = ((^shift_q) ^ par_q) != (PARITY_ODD != 0);
`endif

  // rx is asynchronous: two flops, idle-high reset so no false start after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
`ifdef COM_TO_FIFO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
`ifdef COM_TO_FIFO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    shift_d        = shift_q;
`ifdef COM_TO_FIFO_PARITY_EN
    par_d          = par_q;
`endif
    byte_vld       = 1'b0;
    frame_err_set  = 1'b0;
    parity_err_set = 1'b0;

    if (!enable && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable && !rx_s) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_d          = '0;
            shift_d[idx_q] = rx_s;
            idx_d          = idx_q + 1'b1;
            if (idx_q == 3'd7) begin
`ifdef COM_TO_FIFO_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef COM_TO_FIFO_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt_d   = '0;
            par_d   = rx_s;
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            cnt_d = '0;
`ifdef COM_TO_FIFO_PARITY_EN
            parity_err_set = par_bad;
            byte_vld       = rx_s && !par_bad;
`else
            byte_vld       = rx_s;
`endif
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              frame_err_set = 1'b1;
              state_d       = WAIT_HIGH;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A byte arriving on the write edge refills the holding register, so it is not an overrun
  assign wr = pending_q && !fifo.fifo_busy && !fifo.fifo_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q      <= '0;
      pending_q   <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (byte_vld && (!pending_q || wr)) begin
        data_q    <= shift_q;
        pending_q <= 1'b1;
      end else if (wr) begin
        pending_q <= 1'b0;
      end
      if (byte_vld && pending_q && !wr) overrun_err <= 1'b1;
      if (frame_err_set) frame_err <= 1'b1;
    end
  end

`ifdef COM_TO_FIFO_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else if (parity_err_set) begin
      parity_err <= 1'b1;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign fifo.fifo_data = data_q;
  assign fifo.fifo_we   = wr;
  assign fifo.is_finish = wr;
  assign busy           = (state_q != IDLE) || pending_q;

endmodule

// File: tb/tb_com_to_fifo.sv
// Directed bench for com_to_fifo: UART frames in, FIFO writes scored against a queue of expected bytes.
module tb_com_to_fifo;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic rx;
  logic busy, frame_err, overrun_err, parity_err;

  com_to_fifo_if fif ();

  com_to_fifo #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .rx          (rx),
    .fifo        (fif.master),
    .busy        (busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample mid-cycle on the falling edge, return just after the rising edge
  task automatic tick();
    logic [7:0] exp_b;
    @(negedge clk);
    if (fif.fifo_we === 1'b1) begin
      wr_count++;
      check("is_finish_with_we", {31'd0, fif.is_finish}, 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {24'd0, fif.fifo_data}, 32'hFFFF_FFFF);
      end else begin
        exp_b = exp_q.pop_front();
        check("write_data", {24'd0, fif.fifo_data}, {24'd0, exp_b});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    ticks(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic use_par, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (use_par) drive_bit(par_bit);
    drive_bit(stop_bit);
    rx = 1'b1;
  endtask

  int wr_before;

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    rx = 1'b1;
    fif.fifo_busy = 1'b0;
    fif.fifo_full = 1'b0;
    #23;
    check("rst_fifo_data", {24'd0, fif.fifo_data}, 32'd0);
    check("rst_fifo_we", {31'd0, fif.fifo_we}, 32'd0);
    check("rst_is_finish", {31'd0, fif.is_finish}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_errs", {29'd0, frame_err, overrun_err, parity_err}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    enable = 1'b1;
    ticks(5);

    // Plain byte
    wr_before = wr_count;
    exp_q.push_back(8'h41);
    send_frame(8'h41, 1'b1, 1'b0, 1'b0);
    ticks(30);
    check("byte41_writes", wr_count - wr_before, 32'd1);
    check("byte41_queue_empty", exp_q.size(), 32'd0);
    check("byte41_errs", {29'd0, frame_err, overrun_err, parity_err}, 32'd0);
    check("byte41_idle", {31'd0, busy}, 32'd0);

    // Start glitch
    wr_before = wr_count;
    rx = 1'b0;
    ticks(4);
    rx = 1'b1;
    check("glitch_busy", {31'd0, busy}, 32'd1);
    ticks(30);
    check("glitch_idle", {31'd0, busy}, 32'd0);
    check("glitch_no_write", wr_count - wr_before, 32'd0);
    check("glitch_no_ferr", {31'd0, frame_err}, 32'd0);

    // Bad stop bit followed by a held-low line
    wr_before = wr_count;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    ticks(40);
    check("break_ferr", {31'd0, frame_err}, 32'd1);
    check("break_wait_high", {31'd0, busy}, 32'd1);
    check("break_no_write", wr_count - wr_before, 32'd0);
    rx = 1'b1;
    ticks(10);
    check("break_released", {31'd0, busy}, 32'd0);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1, 1'b0, 1'b0);
    ticks(30);
    check("after_break_write", wr_count - wr_before, 32'd1);
    check("after_break_queue", exp_q.size(), 32'd0);

    // Overrun while FIFO is busy
    wr_before = wr_count;
    fif.fifo_busy = 1'b1;
    exp_q.push_back(8'h10);
    send_frame(8'h10, 1'b1, 1'b0, 1'b0);
    ticks(5);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    ticks(30);
    check("overrun_flag", {31'd0, overrun_err}, 32'd1);
    check("overrun_held", wr_count - wr_before, 32'd0);
    check("overrun_pending_busy", {31'd0, busy}, 32'd1);
    fif.fifo_busy = 1'b0;
    ticks(10);
    check("overrun_single_write", wr_count - wr_before, 32'd1);
    check("overrun_queue", exp_q.size(), 32'd0);
    check("overrun_idle", {31'd0, busy}, 32'd0);

    // FIFO full also blocks
    wr_before = wr_count;
    fif.fifo_full = 1'b1;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    ticks(30);
    check("full_blocks", wr_count - wr_before, 32'd0);
    fif.fifo_full = 1'b0;
    ticks(5);
    check("full_release_write", wr_count - wr_before, 32'd1);

    // enable dropped mid-frame
    wr_before = wr_count;
    rx = 1'b0;
    ticks(CPB * 3);
    enable = 1'b0;
    ticks(2);
    check("enable_drop_idle", {31'd0, busy}, 32'd0);
    ticks(CPB * 7);
    rx = 1'b1;
    ticks(20);
    enable = 1'b1;
    check("enable_drop_no_write", wr_count - wr_before, 32'd0);

    // Reset mid-DATA while a byte is pending and being written
    fif.fifo_busy = 1'b1;
    exp_q.push_back(8'h33);
    send_frame(8'h33, 1'b1, 1'b0, 1'b0);
    ticks(5);
    rx = 1'b0;
    ticks(CPB * 4);
    fif.fifo_busy = 1'b0;
    #1;
    check("pre_reset_we", {31'd0, fif.fifo_we}, 32'd1);
    reset = 1'b1;
    #1;
    void'(exp_q.pop_back());
    check("mid_reset_we", {31'd0, fif.fifo_we}, 32'd0);
    check("mid_reset_finish", {31'd0, fif.is_finish}, 32'd0);
    check("mid_reset_busy", {31'd0, busy}, 32'd0);
    check("mid_reset_data", {24'd0, fif.fifo_data}, 32'd0);
    check("mid_reset_errs", {29'd0, frame_err, overrun_err, parity_err}, 32'd0);
    rx = 1'b1;
    ticks(3);
    reset = 1'b0;
    ticks(5);
    wr_before = wr_count;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
    ticks(30);
    check("post_reset_write", wr_count - wr_before, 32'd1);
    check("post_reset_queue", exp_q.size(), 32'd0);
    check("post_reset_errs", {29'd0, frame_err, overrun_err, parity_err}, 32'd0);

`ifdef COM_TO_FIFO_PARITY_EN
    wr_before = wr_count;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    ticks(30);
    check("parity_bad_flag", {31'd0, parity_err}, 32'd1);
    check("parity_bad_no_write", wr_count - wr_before, 32'd0);
    exp_q.push_back(8'h03);
    send_frame(8'h03, 1'b1, 1'b1, 1'b0);
    ticks(30);
    check("parity_good_write", wr_count - wr_before, 32'd1);
    check("parity_good_queue", exp_q.size(), 32'd0);
`else
    check("parity_tied_low", {31'd0, parity_err}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
